uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and serial-line status for uart_tx_arbiter.
// The design connects through the slave modport; the driving side uses master.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        tx;
  logic        busy;
  logic        grant;
  logic [11:0] frame;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx, busy, grant, frame
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx, busy, grant, frame
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin arbitration, then one
// 12-bit frame (start, data MSB-first, parity, two stops) per acceptance.
//
// state | meaning
// IDLE  | line at 1; READY offered to the arbitration winner
// SEND  | shifting frame[bit_idx] out, CLKS_PER_BIT cycles per bit
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q;
  logic [3:0]  bit_idx_q;
  logic [11:0] frame_q;
  logic        tx_q;
  logic        busy_q;
  logic        grant_q;
  logic        last_q;

  logic        sel;
  logic        ready0;
  logic        ready1;
  logic        accept;
  logic        baud_done;
  logic [7:0]  sel_data;
  logic        parity;
  logic [11:0] new_frame;

  assign baud_done = (baud_q == BAUD_LAST);
  assign sel_data  = sel ? bus.req1_data : bus.req0_data;
  assign parity    = PARITY_ODD ? ~^sel_data : ^sel_data;
  assign new_frame = {1'b0, sel_data, parity, 2'b11};

  always_comb begin
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    accept  = 1'b0;
    // On a tie the requester not served last wins.
    if (bus.req0_valid && bus.req1_valid) sel = ~last_q;
    else                                  sel = bus.req1_valid;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          ready0 = bus.req0_valid && !sel;
          ready1 = bus.req1_valid && sel;
          accept = ready0 || ready1;
          if (accept) state_d = SEND;
        end
      end
      SEND: begin
        if (baud_done && (bit_idx_q == 4'd0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        frame_q   <= new_frame;
        grant_q   <= sel;
        last_q    <= sel;
        bit_idx_q <= 4'd11;
        baud_q    <= '0;
        tx_q      <= new_frame[11];
        busy_q    <= 1'b1;
      end else if (state_q == SEND) begin
        if (baud_done) begin
          baud_q <= '0;
          if (bit_idx_q == 4'd0) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            bit_idx_q <= bit_idx_q - 4'd1;
            tx_q      <= frame_q[bit_idx_q - 4'd1];
          end
        end else begin
          baud_q <= baud_q + 16'd1;
        end
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.frame      = frame_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4, with a second
// odd-parity instance for the parity-sense check.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  uart_tx_arbiter_if bif ();
  uart_tx_arbiter_if bodd ();

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );
  uart_tx_arbiter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .bus(bodd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first sample after acceptance; walks all 48 frame cycles.
  task automatic run_frame(input logic [11:0] exp_frame, input bit disturb);
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    for (int i = 0; i < 48; i++) begin
      check($sformatf("tx_bit%0d_cyc%0d", 11 - i / 4, i), 32'(bif.tx), 32'(exp_frame[11 - i / 4]));
      if (bif.busy) busy_cnt++;
      if (bif.req0_ready || bif.req1_ready) rdy_cnt++;
      if (disturb && i == 10) bif.req0_data = 8'hFF;
      if (disturb && i == 20) bif.req0_valid = 1'b1;
      if (disturb && i == 21) bif.req0_valid = 1'b0;
      tick();
    end
    check("end_tx", 32'(bif.tx), 32'd1);
    check("end_busy", 32'(bif.busy), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'd48);
    check("ready_in_send", 32'(rdy_cnt), 32'd0);
    check("frame_held", 32'(bif.frame), 32'(exp_frame));
  endtask

  int          cyc;
  int          nacc;
  int          t_acc [4];
  logic        who   [4];
  logic        gnt   [4];

  initial begin
    rst = 1'b1;
    bif.req0_valid  = 1'b1;  bif.req0_data  = 8'hA5;
    bif.req1_valid  = 1'b0;  bif.req1_data  = 8'h00;
    bodd.req0_valid = 1'b0;  bodd.req0_data = 8'h00;
    bodd.req1_valid = 1'b0;  bodd.req1_data = 8'h00;
    tick();
    tick();

    check("rst_tx", 32'(bif.tx), 32'd1);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_grant", 32'(bif.grant), 32'd0);
    check("rst_frame", 32'(bif.frame), 32'h000);
    check("rst_ready0", 32'(bif.req0_ready), 32'd0);

    // First idle cycle out of reset: single-cycle request for 8'hA5.
    rst = 1'b0;
    #1;
    check("a5_ready0", 32'(bif.req0_ready), 32'd1);
    check("a5_ready1", 32'(bif.req1_ready), 32'd0);
    tick();
    bif.req0_valid = 1'b0;
    check("a5_frame", 32'(bif.frame), 32'h52B);
    check("a5_grant", 32'(bif.grant), 32'd0);
    check("a5_busy", 32'(bif.busy), 32'd1);
    check("a5_ready_after", 32'(bif.req0_ready), 32'd0);
    run_frame(12'h52B, 1'b1);
    tick();
    tick();
    check("pulse_in_send_ignored", 32'(bif.busy), 32'd0);

    // Requester 1, byte 8'h01, on both parity senses.
    bif.req1_valid  = 1'b1;  bif.req1_data  = 8'h01;
    bodd.req1_valid = 1'b1;  bodd.req1_data = 8'h01;
    #1;
    check("r1_ready1", 32'(bif.req1_ready), 32'd1);
    check("r1_ready0", 32'(bif.req0_ready), 32'd0);
    tick();
    bif.req1_valid  = 1'b0;
    bodd.req1_valid = 1'b0;
    check("r1_frame_even", 32'(bif.frame), 32'h00F);
    check("r1_grant", 32'(bif.grant), 32'd1);
    check("r1_frame_odd", 32'(bodd.frame), 32'h00B);
    check("r1_grant_odd", 32'(bodd.grant), 32'd1);
    run_frame(12'h00F, 1'b0);

    // Both requesters held high from reset: alternate grants, 49-cycle spacing.
    rst = 1'b1;
    bif.req0_valid = 1'b1;  bif.req0_data = 8'h11;
    bif.req1_valid = 1'b1;  bif.req1_data = 8'h22;
    tick();
    tick();
    rst = 1'b0;
    #1;
    cyc  = 0;
    nacc = 0;
    while (nacc < 4 && cyc < 400) begin
      if (bif.req0_ready && bif.req1_ready) check("two_ready", 32'd1, 32'd0);
      if (bif.req0_ready || bif.req1_ready) begin
        t_acc[nacc] = cyc;
        who[nacc]   = bif.req1_ready;
        tick();
        cyc++;
        gnt[nacc]   = bif.grant;
        nacc++;
      end else begin
        tick();
        cyc++;
      end
    end
    check("tie_accept_count", 32'(nacc), 32'd4);
    check("tie_first_cycle", 32'(t_acc[0]), 32'd0);
    for (int k = 0; k < nacc; k++) begin
      check($sformatf("tie_ready_%0d", k), 32'(who[k]), 32'(k % 2));
      check($sformatf("tie_grant_%0d", k), 32'(gnt[k]), 32'(k % 2));
      if (k > 0) check($sformatf("tie_spacing_%0d", k), 32'(t_acc[k] - t_acc[k-1]), 32'd49);
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset during bit 5 of a frame for 8'hC3 (frame 12'h61B, bit 5 = 0).
    bif.req0_valid = 1'b1;  bif.req0_data = 8'hC3;
    tick();
    bif.req0_valid = 1'b0;
    check("c3_frame", 32'(bif.frame), 32'h61B);
    for (int i = 0; i < 25; i++) tick();
    check("c3_bit5_tx", 32'(bif.tx), 32'd0);
    check("c3_bit5_busy", 32'(bif.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready0", 32'(bif.req0_ready), 32'd0);
    tick();
    check("midrst_tx", 32'(bif.tx), 32'd1);
    check("midrst_busy", 32'(bif.busy), 32'd0);
    check("midrst_frame", 32'(bif.frame), 32'h000);
    check("midrst_grant", 32'(bif.grant), 32'd0);

    // Fresh complete frame after the abandoned one.
    rst = 1'b0;
    bif.req0_valid = 1'b1;  bif.req0_data = 8'h5A;
    #1;
    check("5a_ready0", 32'(bif.req0_ready), 32'd1);
    tick();
    bif.req0_valid = 1'b0;
    check("5a_frame", 32'(bif.frame), 32'h2D3);
    check("5a_busy", 32'(bif.busy), 32'd1);
    run_frame(12'h2D3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
